// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: {J,K} mode encodings and the next-state rule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package jk_pkg;

  // Mode is the concatenation {J,K} sampled at the active clock edge
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Next state of one JK bit given its current state and the sampled inputs
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic n;
    n = q;
    case ({j, k})
      JK_HOLD: n = q;
      JK_RST:  n = 1'b0;
      JK_SET:  n = 1'b1;
      JK_TGL:  n = ~q;
      default: n = 1'bx;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single positive-edge JK flip-flop with asynchronous active-low reset to RESET_BIT.
// Latency: one rising clock edge from J/K to q; reset acts immediately.
// Backpressure: none, the cell always accepts J/K on every edge.
module jk_ff_cell
  import jk_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  output logic q,
  input  logic j,
  input  logic k,
  input  logic clock,
  input  logic reset
);

  // Reset overrides any coincident clock edge; otherwise apply the JK rule
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops on one clock and one async active-low reset.
// Latency: one rising clock edge per bit; Q_n follows Q combinationally.
// Backpressure: none, every bit updates on every rising edge.
module jk_ff_bank #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] Q_n
);

  // One cell per bit; bits never interact, so there is no cross-bit logic here
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_cell #(
      .RESET_BIT(RESET_VALUE[i])
    ) u_cell (
      .q    (Q[i]),
      .j    (J[i]),
      .k    (K[i]),
      .clock(clock),
      .reset(reset)
    );
  end

  // Complement output derived from the stored state, so it is valid during reset too
  assign Q_n = ~Q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Scoreboard bench for jk_ff_bank: an 8-bit bank under directed and random J/K/reset,
// plus a 4-stage ripple counter built from single-bit banks.
// Stimulus pushes expectations; independent monitors pop and compare.
module tb_jk_ff_bank;

  localparam int           W  = 8;
  localparam logic [W-1:0] RV = 8'h3C;

  logic         clock = 1'b0;
  logic         rst_n = 1'b1;
  logic         rip_rst_n = 1'b1;
  logic [W-1:0] J = '0;
  logic [W-1:0] K = '0;
  logic [W-1:0] Q;
  logic [W-1:0] Q_n;

  logic [3:0]   rq;
  logic [3:0]   rqn;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] q;
    int           tag;
  } exp_t;

  exp_t         main_q[$];
  logic [3:0]   rip_q[$];
  logic [W-1:0] model_q;
  int           rip_cnt;
  event         chk_ev;

  always #5 clock = ~clock;

  jk_ff_bank #(.WIDTH(W), .RESET_VALUE(RV)) u_dut (
    .Q(Q), .J(J), .K(K), .clock(clock), .reset(rst_n), .Q_n(Q_n)
  );

  // Ripple counter: stage n is clocked by the complement output of stage n-1
  jk_ff_bank u_r0 (.Q(rq[0]), .J(1'b1), .K(1'b1), .clock(clock),  .reset(rip_rst_n), .Q_n(rqn[0]));
  jk_ff_bank u_r1 (.Q(rq[1]), .J(1'b1), .K(1'b1), .clock(rqn[0]), .reset(rip_rst_n), .Q_n(rqn[1]));
  jk_ff_bank u_r2 (.Q(rq[2]), .J(1'b1), .K(1'b1), .clock(rqn[1]), .reset(rip_rst_n), .Q_n(rqn[2]));
  jk_ff_bank u_r3 (.Q(rq[3]), .J(1'b1), .K(1'b1), .clock(rqn[2]), .reset(rip_rst_n), .Q_n(rqn[3]));

  // Reference rule per bit: toggle where J&K, then force set/clear masks
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                            input logic [W-1:0] k);
    logic [W-1:0] tgl, set, clr;
    tgl = j & k;
    set = j & ~k;
    clr = ~j & k;
    return ((q ^ tgl) | set) & ~clr;
  endfunction

  function automatic string tag_name(input int t);
    case (t)
      0: return "falling_edge_hold";
      1: return "rising_edge_update";
      2: return "async_reset_assert";
      3: return "reset_release_hold";
      default: return "unknown";
    endcase
  endfunction

  task automatic push_main(input logic [W-1:0] q, input int tag);
    exp_t e;
    e.q = q;
    e.tag = tag;
    main_q.push_back(e);
  endtask

  // One clock period of stimulus starting at a falling edge.
  // act: 0 = leave reset as is, 1 = assert reset mid-cycle, 2 = release reset mid-cycle
  task automatic step(input logic [W-1:0] j, input logic [W-1:0] k, input int act);
    @(negedge clock);
    push_main(model_q, 0);
    J = j;
    K = k;
    #2;
    if (act == 1 && rst_n) begin
      model_q = RV;
      push_main(RV, 2);
      rst_n = 1'b0;
    end else if (act == 2 && !rst_n) begin
      rst_n = 1'b1;
      rip_rst_n = 1'b1;
      push_main(model_q, 3);
      ->chk_ev;
    end
    if (rst_n) model_q = ref_next(model_q, j, k);
    else       model_q = RV;
    push_main(model_q, 1);
    if (rip_rst_n) rip_cnt = (rip_cnt + 1) % 16;
    else           rip_cnt = 0;
    rip_q.push_back(rip_cnt[3:0]);
  endtask

  // Main monitor: any clock edge, reset assertion or release check presents an output
  initial begin
    exp_t e;
    forever begin
      @(clock or negedge rst_n or chk_ev);
      #1;
      vectors++;
      if (main_q.size() == 0) begin
        miscompares++;
        $display("FAIL main_underflow: Q=%h with no expectation queued at %0t", Q, $time);
      end else begin
        e = main_q.pop_front();
        if (Q !== e.q || Q_n !== ~e.q) begin
          miscompares++;
          $display("FAIL %s: Q=%h Q_n=%h, expected Q=%h Q_n=%h at %0t",
                   tag_name(e.tag), Q, Q_n, e.q, ~e.q, $time);
        end
      end
    end
  end

  // Counter monitor: compares the ripple count after each rising edge
  initial begin
    logic [3:0] ec;
    forever begin
      @(posedge clock);
      #1;
      vectors++;
      if (rip_q.size() == 0) begin
        miscompares++;
        $display("FAIL ripple_underflow: count=%0d with no expectation at %0t", rq, $time);
      end else begin
        ec = rip_q.pop_front();
        if (rq !== ec) begin
          miscompares++;
          $display("FAIL ripple_count: count=%0d, expected %0d at %0t", rq, ec, $time);
        end
      end
    end
  end

  initial begin
    int act;
    model_q = RV;
    rip_cnt = 0;
    // Assert both resets with J=K=1 so the first edges would toggle if reset lost
    #1;
    J = '1;
    K = '1;
    push_main(RV, 2);
    rst_n = 1'b0;
    rip_rst_n = 1'b0;
    push_main(RV, 1);
    rip_q.push_back(4'd0);
    step('1, '1, 0);
    step('1, '1, 0);
    // Release mid-cycle; state must hold until the next rising edge
    step('0, '0, 2);
    // Truth table: hold, reset, set, hold, set, reset
    step('0, '0, 0);
    step('0, '1, 0);
    step('1, '0, 0);
    step('0, '0, 0);
    step('1, '0, 0);
    step('0, '1, 0);
    // Four toggles from zero
    for (int n = 0; n < 4; n++) step('1, '1, 0);
    // Set, then drop reset between edges, then release and set again
    step('1, '0, 0);
    step('1, '0, 1);
    step('1, '0, 2);
    // Bank independence from all-zero state
    step('0, '1, 0);
    step(8'h0A, 8'h06, 0);
    step(8'h0A, 8'h06, 0);
    // Random J/K with occasional mid-cycle reset pulses
    for (int n = 0; n < 80; n++) begin
      act = 0;
      if (rst_n && $urandom_range(0, 9) == 0) act = 1;
      else if (!rst_n && $urandom_range(0, 2) == 0) act = 2;
      step(W'($urandom), W'($urandom), act);
    end
    step('1, '1, 2);
    @(posedge clock);
    #3;
    vectors++;
    if (main_q.size() != 0 || rip_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: main=%0d ripple=%0d, expected 0 and 0",
               main_q.size(), rip_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
